tblink_rpc_cmdout_arb: RTL and testbench

Round-robin arbiter that shares the single outbound-command channel of the tblink RPC command processor among `N_REQ` requesters (e.g. several BFMs in one gateway). Each requester and the downstream channel use the toggle handshake: a request is pending while `put_i != get_i`. The block snapshots the winner's command into the downstream port, waits for downstream completion, and returns the response into that requester's private response slot.

---
 rtl/tblink_rpc_cmdout_arb_if.sv | 31 +++
 rtl/tblink_rpc_cmdout_arb.sv | 70 +++++++
 tb/tb_tblink_rpc_cmdout_arb.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tblink_rpc_cmdout_arb_if.sv
// tblink_rpc_cmdout_arb_if: requester-side and downstream toggle-handshake signals of the command-out arbiter
interface tblink_rpc_cmdout_arb_if #(
  parameter int N_REQ     = 2,
  parameter int PARAMS_SZ = 1,
  parameter int RSP_SZ    = 1
);
  logic [8*N_REQ-1:0]           req_cmd;
  logic [8*N_REQ-1:0]           req_sz;
  logic [8*PARAMS_SZ*N_REQ-1:0] req_params;
  logic [N_REQ-1:0]             req_put_i;
  logic [N_REQ-1:0]             req_get_i;
  logic [8*RSP_SZ*N_REQ-1:0]    req_rsp;
  logic [8*N_REQ-1:0]           req_rsp_sz;
  logic [7:0]                   cmd_out;
  logic [7:0]                   cmd_out_sz;
  logic [8*PARAMS_SZ-1:0]       cmd_out_params;
  logic                         cmd_out_put_i;
  logic                         cmd_out_get_i;
  logic [8*RSP_SZ-1:0]          cmd_out_rsp;
  logic [7:0]                   cmd_out_rsp_sz;
  logic [N_REQ-1:0]             gnt;
  logic                         busy;
  modport slave (
    input  req_cmd, req_sz, req_params, req_put_i, cmd_out_get_i, cmd_out_rsp, cmd_out_rsp_sz,
    output req_get_i, req_rsp, req_rsp_sz, cmd_out, cmd_out_sz, cmd_out_params, cmd_out_put_i, gnt, busy
  );
  modport master (
    output req_cmd, req_sz, req_params, req_put_i, cmd_out_get_i, cmd_out_rsp, cmd_out_rsp_sz,
    input  req_get_i, req_rsp, req_rsp_sz, cmd_out, cmd_out_sz, cmd_out_params, cmd_out_put_i, gnt, busy
  );
endinterface

// File: rtl/tblink_rpc_cmdout_arb.sv
// tblink_rpc_cmdout_arb: round-robin sharing of one toggle-handshake command channel among N_REQ requesters
module tblink_rpc_cmdout_arb #(
  parameter int N_REQ     = 2,
  parameter int PARAMS_SZ = 1,
  parameter int RSP_SZ    = 1
) (
  input  logic                      uclock,
  input  logic                      reset,
  tblink_rpc_cmdout_arb_if.slave    bus
);
  localparam int LW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t           state;
  logic [LW-1:0]    last;
  logic [LW-1:0]    w;
  logic [LW-1:0]    win;
  logic [LW-1:0]    idx;
  logic [N_REQ-1:0] pend;
  assign pend = bus.req_put_i ^ bus.req_get_i;
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = LW'((int'(last) + k) % N_REQ);
      win = pend[idx] ? idx : win;
    end
  end
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      last               <= LW'(N_REQ - 1);
      w                  <= '0;
      bus.req_get_i      <= '0;
      bus.req_rsp        <= '0;
      bus.req_rsp_sz     <= '0;
      bus.cmd_out        <= '0;
      bus.cmd_out_sz     <= '0;
      bus.cmd_out_params <= '0;
      bus.cmd_out_put_i  <= 1'b0;
      bus.gnt            <= '0;
      bus.busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|pend) begin
          w                  <= win;
          bus.cmd_out        <= bus.req_cmd[8*win +: 8];
          bus.cmd_out_sz     <= bus.req_sz[8*win +: 8];
          bus.cmd_out_params <= bus.req_params[8*PARAMS_SZ*win +: 8*PARAMS_SZ];
          bus.cmd_out_put_i  <= ~bus.cmd_out_put_i;
          bus.gnt            <= N_REQ'(1) << win;
          bus.busy           <= 1'b1;
          state              <= WAIT;
        end
        WAIT: if (bus.cmd_out_get_i == bus.cmd_out_put_i) begin
          bus.req_rsp[8*RSP_SZ*w +: 8*RSP_SZ] <= bus.cmd_out_rsp;
          bus.req_rsp_sz[8*w +: 8]            <= bus.cmd_out_rsp_sz;
          state                               <= DONE;
        end
        DONE: begin
          bus.req_get_i[w] <= ~bus.req_get_i[w];
          last             <= w;
          bus.gnt          <= '0;
          bus.busy         <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tblink_rpc_cmdout_arb.sv
// tb_tblink_rpc_cmdout_arb: directed and random checks of the command-out arbiter against a transaction-level model
module tb_tblink_rpc_cmdout_arb;
  localparam int N  = 3;
  localparam int PS = 2;
  localparam int RS = 2;
  localparam int PW = 8*PS;
  localparam int RW = 8*RS;
  logic uclock = 1'b0;
  logic reset  = 1'b0;
  always #5 uclock = ~uclock;
  tblink_rpc_cmdout_arb_if #(.N_REQ(N), .PARAMS_SZ(PS), .RSP_SZ(RS)) bus ();
  tblink_rpc_cmdout_arb #(.N_REQ(N), .PARAMS_SZ(PS), .RSP_SZ(RS)) dut (.uclock(uclock), .reset(reset), .bus(bus));
  int ncmp = 0, nfail = 0, cyc = 0;
  logic [7:0]    r_cmd [N];
  logic [7:0]    r_sz  [N];
  logic [PW-1:0] r_par [N];
  logic [N-1:0]  put_v, mget;
  int            mlast, cur, resp_cyc, dn_lat, dn_cnt;
  bit            outst, waiting, prev_put, dn_get, dn_busy;
  logic [RW-1:0] mrsp    [N];
  logic [7:0]    mrsp_sz [N];
  logic [RW-1:0] exp_rsp;
  logic [7:0]    exp_sz;
  bit            stream [N];
  logic [7:0]    scmd   [N];
  int            order[$], gcyc[$];
  logic [7:0]    cmds[$];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [RW-1:0] rsp_of(input logic [7:0] c, input logic [7:0] s, input logic [PW-1:0] p);
    return {p[7:0] ^ s, c};
  endfunction
  function automatic int rr(input logic [N-1:0] p, input int l);
    for (int k = 1; k <= N; k++) if (p[(l + k) % N]) return (l + k) % N;
    return 0;
  endfunction
  function automatic logic [RW*N-1:0] pack_rsp();
    logic [RW*N-1:0] v;
    for (int i = 0; i < N; i++) v[RW*i +: RW] = mrsp[i];
    return v;
  endfunction
  function automatic logic [8*N-1:0] pack_sz();
    logic [8*N-1:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = mrsp_sz[i];
    return v;
  endfunction
  function automatic bit pending(input int i);
    return put_v[i] ^ mget[i];
  endfunction
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_cmd[8*i +: 8]     = r_cmd[i];
      bus.req_sz[8*i +: 8]      = r_sz[i];
      bus.req_params[PW*i +: PW] = r_par[i];
    end
    bus.req_put_i = put_v;
  endtask
  task automatic request(input int i, input logic [7:0] c, input logic [7:0] s, input logic [PW-1:0] p);
    r_cmd[i] = c;
    r_sz[i]  = s;
    r_par[i] = p;
    put_v[i] = ~put_v[i];
    drive();
  endtask
  // One clock: check grant/response/completion events against the model, then run the downstream responder.
  task automatic step();
    logic [N-1:0] pend;
    bit sg, granted;
    int w;
    @(posedge uclock); #1;
    cyc++;
    pend    = put_v ^ mget;
    sg      = !outst && pend != 0;
    granted = (bus.cmd_out_put_i !== prev_put);
    chk("grant_timing", 64'(granted), 64'(sg));
    if (granted) begin
      w = rr(pend, mlast);
      chk("grant_gnt", 64'(bus.gnt), 64'(N'(1) << w));
      chk("grant_cmd", 64'(bus.cmd_out), 64'(r_cmd[w]));
      chk("grant_sz", 64'(bus.cmd_out_sz), 64'(r_sz[w]));
      chk("grant_params", 64'(bus.cmd_out_params), 64'(r_par[w]));
      exp_rsp  = rsp_of(r_cmd[w], r_sz[w], r_par[w]);
      exp_sz   = r_sz[w] + 8'd1;
      outst    = 1;
      cur      = w;
      prev_put = bus.cmd_out_put_i;
      order.push_back(w);
      gcyc.push_back(cyc);
      cmds.push_back(bus.cmd_out);
    end
    if (waiting && cyc == resp_cyc + 1) begin
      mrsp[cur]    = exp_rsp;
      mrsp_sz[cur] = exp_sz;
      chk("rsp_write", 64'(bus.req_rsp), 64'(pack_rsp()));
      chk("rsp_sz_write", 64'(bus.req_rsp_sz), 64'(pack_sz()));
      chk("get_not_yet", 64'(bus.req_get_i), 64'(mget));
    end
    if (bus.req_get_i !== mget) begin
      chk("get_toggle", 64'(bus.req_get_i), 64'(mget ^ (N'(1) << cur)));
      chk("done_timing", 64'(cyc - resp_cyc), 64'd2);
      mget    = mget ^ (N'(1) << cur);
      mlast   = cur;
      outst   = 0;
      waiting = 0;
      chk("rsp_hold", 64'(bus.req_rsp), 64'(pack_rsp()));
    end
    chk("busy", 64'(bus.busy), 64'(outst));
    chk("gnt", 64'(bus.gnt), outst ? 64'(N'(1) << cur) : 64'd0);
    if (!dn_busy && bus.cmd_out_put_i !== dn_get) begin
      dn_busy = 1;
      dn_cnt  = dn_lat;
    end
    if (dn_busy) begin
      if (dn_cnt == 0) begin
        bus.cmd_out_rsp    = rsp_of(bus.cmd_out, bus.cmd_out_sz, bus.cmd_out_params);
        bus.cmd_out_rsp_sz = bus.cmd_out_sz + 8'd1;
        dn_get             = bus.cmd_out_put_i;
        bus.cmd_out_get_i  = dn_get;
        dn_busy            = 0;
        waiting            = 1;
        resp_cyc           = cyc;
      end else dn_cnt--;
    end
  endtask
  task automatic cycle();
    step();
    for (int i = 0; i < N; i++)
      if (stream[i] && !pending(i)) request(i, scmd[i], 8'(i), PW'(i * 16 + 1));
  endtask
  task automatic drain(input int max);
    int n;
    n = 0;
    while ((outst || (put_v ^ mget) != 0) && n < max) begin
      step();
      n++;
    end
    chk("drain_bound", 64'(n < max), 64'd1);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_get", 64'(bus.req_get_i), 64'd0);
    chk("rst_rsp", 64'(bus.req_rsp), 64'd0);
    chk("rst_rsp_sz", 64'(bus.req_rsp_sz), 64'd0);
    chk("rst_cmd", 64'(bus.cmd_out), 64'd0);
    chk("rst_sz", 64'(bus.cmd_out_sz), 64'd0);
    chk("rst_params", 64'(bus.cmd_out_params), 64'd0);
    chk("rst_put", 64'(bus.cmd_out_put_i), 64'd0);
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    put_v = '0;
    mget  = '0;
    mlast = N - 1;
    cur   = 0;
    for (int i = 0; i < N; i++) begin
      r_cmd[i] = '0; r_sz[i] = '0; r_par[i] = '0;
      mrsp[i] = '0; mrsp_sz[i] = '0; stream[i] = 0;
    end
    drive();
    outst = 0; waiting = 0; prev_put = 0; dn_get = 0; dn_busy = 0;
    bus.cmd_out_get_i  = 1'b0;
    bus.cmd_out_rsp    = '0;
    bus.cmd_out_rsp_sz = '0;
    order.delete(); gcyc.delete(); cmds.delete();
    @(posedge uclock); #1;
    reset = 1'b0;
  endtask
  initial begin
    dn_lat = 3;
    #3;
    do_reset();
    // single request with a 3-cycle downstream
    request(0, 8'h05, 8'h00, PW'(16'h00AB));
    step();
    chk("single_gnt", 64'(bus.gnt), 64'b001);
    chk("single_cmd", 64'(bus.cmd_out), 64'h05);
    chk("single_params", 64'(bus.cmd_out_params), 64'h00AB);
    chk("single_put", 64'(bus.cmd_out_put_i), 64'd1);
    drain(20);
    chk("single_rsp0", 64'(bus.req_rsp[RW-1:0]), 64'hAB05);
    chk("single_get", 64'(bus.req_get_i), 64'b001);
    // simultaneous requests straight after reset
    do_reset();
    request(0, 8'h01, 8'h00, PW'(16'h0010));
    request(1, 8'h02, 8'h00, PW'(16'h0020));
    while (mget[0] == 1'b0 && cyc < 2000) step();
    chk("simul_slot1_untouched", 64'(bus.req_rsp[RW +: RW]), 64'd0);
    drain(30);
    chk("simul_count", 64'(order.size()), 64'd2);
    chk("simul_first", 64'(order[0]), 64'd0);
    chk("simul_second", 64'(order[1]), 64'd1);
    chk("simul_cmd_first", 64'(cmds[0]), 64'h01);
    chk("simul_cmd_second", 64'(cmds[1]), 64'h02);
    // fairness: both requesters re-request on every completion
    do_reset();
    dn_lat = 2;
    scmd[0] = 8'h31; scmd[1] = 8'h32;
    stream[0] = 1; stream[1] = 1;
    for (int t = 0; t < 40; t++) cycle();
    stream[0] = 0; stream[1] = 0;
    drain(30);
    chk("fair_enough_grants", 64'(order.size() >= 6), 64'd1);
    for (int k = 1; k < order.size(); k++) chk("fair_alternate", 64'(order[k] != order[k-1]), 64'd1);
    // wrap-around: serve req2, then req0 and req1 both pending
    do_reset();
    dn_lat = 3;
    request(2, 8'h77, 8'h01, PW'(16'h1234));
    step();
    request(0, 8'h70, 8'h02, PW'(16'h5678));
    request(1, 8'h71, 8'h03, PW'(16'h9ABC));
    drain(40);
    chk("wrap_count", 64'(order.size()), 64'd3);
    chk("wrap_0", 64'(order[0]), 64'd2);
    chk("wrap_1", 64'(order[1]), 64'd0);
    chk("wrap_2", 64'(order[2]), 64'd1);
    // reset while waiting on downstream
    do_reset();
    dn_lat = 6;
    request(1, 8'h44, 8'h05, PW'(16'h4444));
    step();
    step();
    chk("wait_busy", 64'(bus.busy), 64'd1);
    do_reset();
    dn_lat = 1;
    request(1, 8'h45, 8'h06, PW'(16'h4545));
    step();
    chk("after_rst_gnt", 64'(bus.gnt), 64'b010);
    drain(20);
    chk("after_rst_get", 64'(bus.req_get_i), 64'b010);
    // zero-latency downstream with both requesters streaming
    do_reset();
    dn_lat = 0;
    scmd[0] = 8'h11; scmd[1] = 8'h22;
    stream[0] = 1; stream[1] = 1;
    for (int t = 0; t < 30; t++) cycle();
    stream[0] = 0; stream[1] = 0;
    drain(20);
    for (int k = 1; k < gcyc.size(); k++) chk("zero_lat_period", 64'(gcyc[k] - gcyc[k-1]), 64'd3);
    chk("zero_lat_rsp0", 64'(bus.req_rsp[7:0]), 64'h11);
    chk("zero_lat_rsp1", 64'(bus.req_rsp[RW +: 8]), 64'h22);
    // random traffic with occasional withdrawn requests
    do_reset();
    for (int t = 0; t < 600; t++) begin
      dn_lat = $urandom_range(0, 4);
      for (int i = 0; i < N; i++) begin
        if (!pending(i) && $urandom_range(0, 2) == 0)
          request(i, 8'($urandom), 8'($urandom), PW'($urandom));
        else if (pending(i) && outst && cur != i && $urandom_range(0, 15) == 0) begin
          put_v[i] = ~put_v[i];
          drive();
        end
      end
      step();
    end
    drain(60);
    chk("rand_final_rsp", 64'(bus.req_rsp), 64'(pack_rsp()));
    chk("rand_final_get", 64'(bus.req_get_i), 64'(mget));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
